redmule_z_packer: RTL



---
 rtl/redmule_pkg.sv | 33 +++
 rtl/redmule_zpack_buf.sv | 86 ++++++++
 rtl/redmule_z_packer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/redmule_pkg.sv
// -----------------------------------------------------------------------------
// redmule_pkg
// Shared types and constants for the RedMulE Z-stream packer.
//   zpack_state_e   : packer control states (IDLE, RUN, DRAIN, DONE)
//   zpack_cfg_t     : latched job configuration {row_len, rows}
//   ZPackInElems    : default elements per engine result beat
//   ZPackOutElems   : default elements per packed Z-stream word
//   ZPackCntW       : width of the row-length / row-count config fields
//   zpack_cfg_valid : a job is only runnable when both config fields are nonzero
// -----------------------------------------------------------------------------
package redmule_pkg;

  localparam int unsigned ZPackInElems  = 4;
  localparam int unsigned ZPackOutElems = 16;
  localparam int unsigned ZPackCntW     = 16;

  typedef enum logic [1:0] {
    ZPACK_IDLE  = 2'd0,
    ZPACK_RUN   = 2'd1,
    ZPACK_DRAIN = 2'd2,
    ZPACK_DONE  = 2'd3
  } zpack_state_e;

  typedef struct packed {
    logic [ZPackCntW-1:0] row_len;
    logic [ZPackCntW-1:0] rows;
  } zpack_cfg_t;

  function automatic logic zpack_cfg_valid(input zpack_cfg_t cfg);
    return (cfg.row_len != {ZPackCntW{1'b0}}) && (cfg.rows != {ZPackCntW{1'b0}});
  endfunction

endpackage

// File: rtl/redmule_zpack_buf.sv
// -----------------------------------------------------------------------------
// redmule_zpack_buf
// Two-entry ready/valid buffer carrying one packed word {strb, data}.
// The caller must not push while full_o is high; a push and a pop in the same
// cycle with one entry stored keeps the occupancy at one.
// Ports:
//   clk_i, rst_ni (sync, active-low), clear_i (sync soft clear)
//   push_i, push_data_i           : write side
//   full_o, empty_o               : occupancy flags
//   out_valid_o, out_data_o,
//   out_ready_i                   : read side (head entry, stable until popped)
// -----------------------------------------------------------------------------
module redmule_zpack_buf #(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_ready_i
);

  logic [DW-1:0] mem_q [2];
  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic          pop_s;

  assign empty_o     = (count_q == 2'd0);
  assign full_o      = (count_q == 2'd2);
  assign out_valid_o = !empty_o;
  assign out_data_o  = mem_q[rd_ptr_q];
  assign pop_s       = out_valid_o && out_ready_i;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; clearing zeroes the entries so the output reads 0.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= {DW{1'b0}};
      mem_q[1] <= {DW{1'b0}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clear_i) begin
      mem_q[0] <= {DW{1'b0}};
      mem_q[1] <= {DW{1'b0}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/redmule_z_packer.sv
// -----------------------------------------------------------------------------
// redmule_z_packer
// Packs narrow RedMulE result beats (IN_ELEMS elements) into full Z-stream
// words (OUT_ELEMS elements) with byte strobes. A row end closes the current
// word early; elements past the row length are dropped and their slots stay 0.
// Finished words go through a 2-entry buffer (redmule_zpack_buf).
// Ports:
//   clk_i, rst_ni (sync, active-low), clear_i (sync soft clear, top priority)
//   start_i, cfg_row_len_i, cfg_rows_i : job start and configuration (IDLE only)
//   in_data_i, in_valid_i, in_ready_o  : engine beat stream
//   out_data_o, out_strb_o,
//   out_valid_o, out_ready_i           : packed word stream toward the store path
//   busy_o                             : not IDLE
//   done_o                             : one-cycle completion pulse
// Optional build macro REDMULE_ZPACK_PERF_EN adds perf_stall_o, a saturating
// count of RUN cycles where a beat is offered but cannot be accepted.
// -----------------------------------------------------------------------------
module redmule_z_packer
  import redmule_pkg::*;
#(
  parameter int unsigned BITW      = 16,
  parameter int unsigned IN_ELEMS  = ZPackInElems,
  parameter int unsigned OUT_ELEMS = ZPackOutElems,
  parameter int unsigned CNT_W     = ZPackCntW
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        start_i,
  input  logic [CNT_W-1:0]            cfg_row_len_i,
  input  logic [CNT_W-1:0]            cfg_rows_i,
  input  logic [IN_ELEMS*BITW-1:0]    in_data_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic [OUT_ELEMS*BITW-1:0]   out_data_o,
  output logic [OUT_ELEMS*BITW/8-1:0] out_strb_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        busy_o,
  output logic                        done_o
`ifdef REDMULE_ZPACK_PERF_EN
  ,
  output logic [31:0]                 perf_stall_o
`endif
);

  localparam int unsigned EB     = BITW / 8;
  localparam int unsigned DATA_W = OUT_ELEMS * BITW;
  localparam int unsigned STRB_W = OUT_ELEMS * EB;
  localparam int unsigned SLOT_W = $clog2(OUT_ELEMS) + 1;

  if ((OUT_ELEMS % IN_ELEMS) != 0) begin : g_elems_chk
    $error("redmule_z_packer: OUT_ELEMS must be a multiple of IN_ELEMS");
  end
  if ((BITW % 8) != 0) begin : g_bitw_chk
    $error("redmule_z_packer: BITW must be a multiple of 8");
  end
  if (CNT_W != ZPackCntW) begin : g_cntw_chk
    $error("redmule_z_packer: CNT_W must match the zpack_cfg_t field width");
  end

  zpack_state_e          state_q, state_d;
  zpack_cfg_t            cfg_q, cfg_d;
  logic [CNT_W-1:0]      elem_cnt_q, elem_cnt_d;
  logic [CNT_W-1:0]      row_cnt_q, row_cnt_d;
  logic [SLOT_W-1:0]     slot_cnt_q, slot_cnt_d;
  logic [DATA_W-1:0]     asm_data_q, asm_data_d;
  logic [STRB_W-1:0]     asm_strb_q, asm_strb_d;

  logic [CNT_W-1:0]      remaining_s;
  logic [IN_ELEMS-1:0]   elem_valid_s;
  logic [DATA_W-1:0]     merged_data_s;
  logic [STRB_W-1:0]     merged_strb_s;
  logic                  row_end_s;
  logic                  slots_full_s;
  logic                  close_s;
  logic                  last_row_s;
  logic                  accept_s;
  logic                  push_s;
  logic                  buf_full_s;
  logic                  buf_empty_s;
  logic [STRB_W+DATA_W-1:0] buf_out_s;

  // Elements left in the current row; elem_cnt_q never reaches row_len inside
  // a row, so this subtraction cannot wrap and no counter needs an extra bit.
  assign remaining_s  = cfg_q.row_len - elem_cnt_q;
  assign row_end_s    = (remaining_s <= CNT_W'(IN_ELEMS));
  assign slots_full_s = (slot_cnt_q == SLOT_W'(OUT_ELEMS - IN_ELEMS));
  assign close_s      = row_end_s || slots_full_s;
  assign last_row_s   = (row_cnt_q == (cfg_q.rows - CNT_W'(1)));

  assign in_ready_o = (state_q == ZPACK_RUN) && !buf_full_s;
  assign accept_s   = in_valid_i && in_ready_o;
  assign push_s     = accept_s && close_s;

  assign busy_o = (state_q != ZPACK_IDLE);
  assign done_o = (state_q == ZPACK_DONE);

  // Merge the incoming beat into the assembly word; masked elements leave
  // their slots untouched (they are already 0 after the previous close).
  always_comb begin
    merged_data_s = asm_data_q;
    merged_strb_s = asm_strb_q;
    for (int k = 0; k < int'(IN_ELEMS); k++) begin
      elem_valid_s[k] = (CNT_W'(k) < remaining_s);
      merged_data_s[(int'(slot_cnt_q) + k)*BITW +: BITW] =
        elem_valid_s[k] ? in_data_i[k*BITW +: BITW]
                        : asm_data_q[(int'(slot_cnt_q) + k)*BITW +: BITW];
      merged_strb_s[(int'(slot_cnt_q) + k)*EB +: EB] =
        elem_valid_s[k] ? {EB{1'b1}}
                        : asm_strb_q[(int'(slot_cnt_q) + k)*EB +: EB];
    end
  end

  // Control FSM next-state together with the packing counters.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    elem_cnt_d = elem_cnt_q;
    row_cnt_d  = row_cnt_q;
    slot_cnt_d = slot_cnt_q;
    asm_data_d = asm_data_q;
    asm_strb_d = asm_strb_q;
    case (state_q)
      ZPACK_IDLE: begin
        if (start_i) begin
          cfg_d.row_len = cfg_row_len_i;
          cfg_d.rows    = cfg_rows_i;
          elem_cnt_d    = {CNT_W{1'b0}};
          row_cnt_d     = {CNT_W{1'b0}};
          slot_cnt_d    = {SLOT_W{1'b0}};
          asm_data_d    = {DATA_W{1'b0}};
          asm_strb_d    = {STRB_W{1'b0}};
          if (zpack_cfg_valid(cfg_d)) begin
            state_d = ZPACK_RUN;
          end else begin
            state_d = ZPACK_DONE;
          end
        end else begin
          state_d = ZPACK_IDLE;
        end
      end
      ZPACK_RUN: begin
        if (accept_s) begin
          if (close_s) begin
            slot_cnt_d = {SLOT_W{1'b0}};
            asm_data_d = {DATA_W{1'b0}};
            asm_strb_d = {STRB_W{1'b0}};
            if (row_end_s) begin
              elem_cnt_d = {CNT_W{1'b0}};
              row_cnt_d  = row_cnt_q + CNT_W'(1);
              if (last_row_s) begin
                state_d = ZPACK_DRAIN;
              end else begin
                state_d = ZPACK_RUN;
              end
            end else begin
              elem_cnt_d = elem_cnt_q + CNT_W'(IN_ELEMS);
              state_d    = ZPACK_RUN;
            end
          end else begin
            slot_cnt_d = slot_cnt_q + SLOT_W'(IN_ELEMS);
            elem_cnt_d = elem_cnt_q + CNT_W'(IN_ELEMS);
            asm_data_d = merged_data_s;
            asm_strb_d = merged_strb_s;
            state_d    = ZPACK_RUN;
          end
        end else begin
          state_d = ZPACK_RUN;
        end
      end
      ZPACK_DRAIN: begin
        if (buf_empty_s) begin
          state_d = ZPACK_DONE;
        end else begin
          state_d = ZPACK_DRAIN;
        end
      end
      ZPACK_DONE: begin
        state_d = ZPACK_IDLE;
      end
      default: begin
        state_d = ZPACK_IDLE;
      end
    endcase
  end

  // State, latched config, packing counters and assembly register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ZPACK_IDLE;
      cfg_q      <= '{row_len: {CNT_W{1'b0}}, rows: {CNT_W{1'b0}}};
      elem_cnt_q <= {CNT_W{1'b0}};
      row_cnt_q  <= {CNT_W{1'b0}};
      slot_cnt_q <= {SLOT_W{1'b0}};
      asm_data_q <= {DATA_W{1'b0}};
      asm_strb_q <= {STRB_W{1'b0}};
    end else if (clear_i) begin
      state_q    <= ZPACK_IDLE;
      cfg_q      <= '{row_len: {CNT_W{1'b0}}, rows: {CNT_W{1'b0}}};
      elem_cnt_q <= {CNT_W{1'b0}};
      row_cnt_q  <= {CNT_W{1'b0}};
      slot_cnt_q <= {SLOT_W{1'b0}};
      asm_data_q <= {DATA_W{1'b0}};
      asm_strb_q <= {STRB_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      elem_cnt_q <= elem_cnt_d;
      row_cnt_q  <= row_cnt_d;
      slot_cnt_q <= slot_cnt_d;
      asm_data_q <= asm_data_d;
      asm_strb_q <= asm_strb_d;
    end
  end

  redmule_zpack_buf #(
    .DW (STRB_W + DATA_W)
  ) i_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .push_i      (push_s),
    .push_data_i ({merged_strb_s, merged_data_s}),
    .full_o      (buf_full_s),
    .empty_o     (buf_empty_s),
    .out_valid_o (out_valid_o),
    .out_data_o  (buf_out_s),
    .out_ready_i (out_ready_i)
  );

  assign out_data_o = buf_out_s[DATA_W-1:0];
  assign out_strb_o = buf_out_s[STRB_W+DATA_W-1:DATA_W];

`ifdef REDMULE_ZPACK_PERF_EN
  logic [31:0] perf_stall_q;

  // Saturating count of RUN cycles where the engine is held off.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_stall_q <= 32'd0;
    end else if (clear_i) begin
      perf_stall_q <= 32'd0;
    end else if ((state_q == ZPACK_IDLE) && (state_d == ZPACK_RUN)) begin
      perf_stall_q <= 32'd0;
    end else if ((state_q == ZPACK_RUN) && in_valid_i && !in_ready_o &&
                 (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_q <= perf_stall_q + 32'd1;
    end else begin
      perf_stall_q <= perf_stall_q;
    end
  end

  assign perf_stall_o = perf_stall_q;
`endif

endmodule
